// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between a data cache and an
// instruction cache.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   *_Mem_data / *_data   data-cache side: read/write-back requests, address,
//                         write line, returned fill line, completion pulse
//   *_Mem_instr / *_instr instruction-cache side: fill request, address,
//                         returned fill line, completion pulse
//   read_Mem, write_Mem,  memory side: strobes, address and write line,
//   Addr_Mem, ...         held until ready_mem; Data_Mem_read valid with ready_mem
//
// Data cache normally has priority. A starvation counter forces an
// instruction grant after STARVE_LIM data grants made while the instruction
// cache was waiting.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_W     = 128,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    // data cache
    input  logic              read_Mem_data,
    input  logic              write_Mem_data,
    input  logic [ADDR_W-1:0] Addr_Mem_data,
    input  logic [LINE_W-1:0] Data_Mem_data_write,
    output logic [LINE_W-1:0] Data_Mem_data_read,
    output logic              ready_mem_data,
    // instruction cache
    input  logic              read_Mem_instr,
    input  logic [ADDR_W-1:0] Addr_Mem_instr,
    output logic [LINE_W-1:0] Data_Mem_instr_read,
    output logic              ready_mem_instr,
    // memory
    output logic              read_Mem,
    output logic              write_Mem,
    output logic [ADDR_W-1:0] Addr_Mem,
    output logic [LINE_W-1:0] Data_Mem_write,
    input  logic [LINE_W-1:0] Data_Mem_read,
    input  logic              ready_mem
);

    localparam int unsigned CntW =
        ($clog2(STARVE_LIM + 1) > 3) ? $clog2(STARVE_LIM + 1) : 3;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIM);

    typedef enum logic [1:0] {StIdle, StBusyD, StBusyI, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] rdata_dc_q, rdata_dc_d;
    logic [LINE_W-1:0] rdata_ic_q, rdata_ic_d;
    logic              rdy_dc_q, rdy_dc_d;
    logic              rdy_ic_q, rdy_ic_d;

    logic data_req;
    logic instr_forced;

    assign data_req     = read_Mem_data | write_Mem_data;
    // Instruction side overrides data priority once starvation limit is hit.
    assign instr_forced = read_Mem_instr && (starve_q == StarveMax);

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        rdata_dc_d = rdata_dc_q;
        rdata_ic_d = rdata_ic_q;
        rdy_dc_d   = 1'b0;
        rdy_ic_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (data_req && !instr_forced) begin
                    state_d = StBusyD;
                    addr_d  = Addr_Mem_data;
                    // Write-back goes first; a still-held read is a later grant.
                    wr_d    = write_Mem_data;
                    rd_d    = !write_Mem_data;
                    if (write_Mem_data) begin
                        wdata_d = Data_Mem_data_write;
                    end
                    // instr_forced is low here, so starve_q < StarveMax when
                    // read_Mem_instr is high and the increment cannot wrap.
                    if (read_Mem_instr) begin
                        starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                end else if (read_Mem_instr) begin
                    state_d  = StBusyI;
                    addr_d   = Addr_Mem_instr;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                    starve_d = '0;
                end else begin
                    starve_d = '0;
                end
            end
            StBusyD: begin
                if (ready_mem) begin
                    state_d  = StResp;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    rdy_dc_d = 1'b1;
                    if (rd_q) begin
                        rdata_dc_d = Data_Mem_read;
                    end
                end
            end
            StBusyI: begin
                if (ready_mem) begin
                    state_d    = StResp;
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    rdy_ic_d   = 1'b1;
                    rdata_ic_d = Data_Mem_read;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            starve_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rdata_dc_q <= '0;
            rdata_ic_q <= '0;
            rdy_dc_q   <= 1'b0;
            rdy_ic_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            rdata_dc_q <= rdata_dc_d;
            rdata_ic_q <= rdata_ic_d;
            rdy_dc_q   <= rdy_dc_d;
            rdy_ic_q   <= rdy_ic_d;
        end
    end

    assign read_Mem            = rd_q;
    assign write_Mem           = wr_q;
    assign Addr_Mem            = addr_q;
    assign Data_Mem_write      = wdata_q;
    assign Data_Mem_data_read  = rdata_dc_q;
    assign Data_Mem_instr_read = rdata_ic_q;
    assign ready_mem_data      = rdy_dc_q;
    assign ready_mem_instr     = rdy_ic_q;

endmodule
